// File: rtl/unit_arbiter.sv
// unit_arbiter: round-robin front end that multiplexes per-thread requests onto one shared execution unit.
// Optional watchdog is compiled in by defining UNIT_ARB_TIMEOUT_EN.
module unit_arbiter #(
    parameter int NUM_THREADS    = 4,
    parameter int WORD_W         = 32,
    parameter int SEL_W          = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_THREADS-1:0]        req_valid,
    output logic [NUM_THREADS-1:0]        req_ready,
    input  logic [NUM_THREADS*SEL_W-1:0]  req_sel,
    input  logic [NUM_THREADS*WORD_W-1:0] req_ctrl,
    input  logic [NUM_THREADS*WORD_W-1:0] req_in0,
    input  logic [NUM_THREADS*WORD_W-1:0] req_in1,
    output logic [NUM_THREADS-1:0]        rsp_valid,
    output logic [WORD_W-1:0]             rsp_data,
    output logic                          rsp_err,
    output logic [SEL_W-1:0]              unit_sel,
    output logic [WORD_W-1:0]             unit_ctrl,
    output logic [WORD_W-1:0]             unit_in0,
    output logic [WORD_W-1:0]             unit_in1,
    output logic                          unit_valid,
    input  logic                          unit_ready,
    input  logic                          unit_done,
    input  logic [WORD_W-1:0]             unit_out
);

    localparam int PTR_W = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_q, rr_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [WORD_W-1:0]  ctrl_q, ctrl_d;
    logic [WORD_W-1:0]  in0_q, in0_d;
    logic [WORD_W-1:0]  in1_q, in1_d;
    logic [WORD_W-1:0]  data_q, data_d;

    logic               grant_found;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W-1:0]   cand;
    logic               accept;
    logic               timeout_hit;

    // Scan from rr_q upward with wrap; the first requester found wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_THREADS; k++) begin
            cand = PTR_W'((int'(rr_q) + k) % NUM_THREADS);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign accept = (state_q == S_IDLE) && grant_found && !rst;

    always_comb begin
        // NOTE: every output and next-state signal is defaulted first so no path through the case infers a latch.
        state_d    = state_q;
        rr_d       = rr_q;
        owner_d    = owner_q;
        sel_d      = sel_q;
        ctrl_d     = ctrl_q;
        in0_d      = in0_q;
        in1_d      = in1_q;
        data_d     = data_q;
        req_ready  = '0;
        rsp_valid  = '0;
        rsp_data   = '0;
        unit_valid = 1'b0;
        unit_sel   = '0;
        unit_ctrl  = '0;
        unit_in0   = '0;
        unit_in1   = '0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    req_ready[grant_idx] = 1'b1;
                    owner_d = grant_idx;
                    sel_d   = req_sel[grant_idx*SEL_W +: SEL_W];
                    ctrl_d  = req_ctrl[grant_idx*WORD_W +: WORD_W];
                    in0_d   = req_in0[grant_idx*WORD_W +: WORD_W];
                    in1_d   = req_in1[grant_idx*WORD_W +: WORD_W];
                    data_d  = '0;
                    // Unit select 0 means "no unit": answer directly with zero.
                    state_d = (req_sel[grant_idx*SEL_W +: SEL_W] == '0) ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: begin
                unit_sel   = sel_q;
                unit_ctrl  = ctrl_q;
                unit_in0   = in0_q;
                unit_in1   = in1_q;
                unit_valid = !timeout_hit;
                if (timeout_hit) begin
                    data_d  = '0;
                    state_d = S_RESP;
                end else if (unit_ready) begin
                    if (unit_done) begin
                        data_d  = unit_out;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                unit_sel  = sel_q;
                unit_ctrl = ctrl_q;
                unit_in0  = in0_q;
                unit_in1  = in1_q;
                if (timeout_hit) begin
                    data_d  = '0;
                    state_d = S_RESP;
                end else if (unit_done) begin
                    data_d  = unit_out;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid[owner_q] = 1'b1;
                rsp_data = data_q;
                rr_d     = (owner_q == PTR_W'(NUM_THREADS - 1)) ? '0 : owner_q + 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            owner_q <= '0;
            sel_q   <= '0;
            ctrl_q  <= '0;
            in0_q   <= '0;
            in1_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            sel_q   <= sel_d;
            ctrl_q  <= ctrl_d;
            in0_q   <= in0_d;
            in1_q   <= in1_d;
            data_q  <= data_d;
        end
    end

`ifdef UNIT_ARB_TIMEOUT_EN
    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              err_q, err_d;
    logic              busy;

    assign busy        = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign timeout_hit = busy && (wdog_q >= WDOG_W'(TIMEOUT_CYCLES - 1)) && !unit_done;
    assign rsp_err     = (state_q == S_RESP) && err_q;

    // The counter saturates so a late compare can never wrap back to zero.
    always_comb begin
        wdog_d = wdog_q;
        err_d  = err_q;
        if (accept) begin
            wdog_d = '0;
            err_d  = 1'b0;
        end else if (busy) begin
            if (timeout_hit) begin
                err_d = 1'b1;
            end
            if (wdog_q != WDOG_W'(TIMEOUT_CYCLES)) begin
                wdog_d = wdog_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign rsp_err            = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_unit_arbiter.sv
// Self-checking bench for unit_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level round-robin model.
module tb_unit_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int S  = 3;
    localparam int TO = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid, req_ready, rsp_valid;
    logic [N*S-1:0]   req_sel;
    logic [N*W-1:0]   req_ctrl, req_in0, req_in1;
    logic [W-1:0]     rsp_data;
    logic             rsp_err;
    logic [S-1:0]     unit_sel;
    logic [W-1:0]     unit_ctrl, unit_in0, unit_in1, unit_out;
    logic             unit_valid, unit_ready, unit_done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    unit_arbiter #(
        .NUM_THREADS(N), .WORD_W(W), .SEL_W(S), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
        .req_ctrl(req_ctrl), .req_in0(req_in0), .req_in1(req_in1),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .unit_sel(unit_sel), .unit_ctrl(unit_ctrl), .unit_in0(unit_in0), .unit_in1(unit_in1),
        .unit_valid(unit_valid), .unit_ready(unit_ready), .unit_done(unit_done), .unit_out(unit_out)
    );

    // Behaviour of the shared execution unit used by the bench.
    function automatic logic [W-1:0] unit_fn(input logic [S-1:0] s, input logic [W-1:0] c,
                                             input logic [W-1:0] a, input logic [W-1:0] b);
        return (a + b) ^ c ^ W'(s);
    endfunction

    task automatic idle_inputs();
        req_valid  = '0;
        req_sel    = '0;
        req_ctrl   = '0;
        req_in0    = '0;
        req_in1    = '0;
        unit_ready = 1'b0;
        unit_done  = 1'b0;
        unit_out   = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_req(input int t, input logic [S-1:0] s, input logic [W-1:0] c,
                           input logic [W-1:0] a, input logic [W-1:0] b);
        req_valid[t]      = 1'b1;
        req_sel[t*S +: S] = s;
        req_ctrl[t*W +: W] = c;
        req_in0[t*W +: W]  = a;
        req_in1[t*W +: W]  = b;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        @(negedge clk); #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_data, rsp_err, unit_valid, unit_sel, unit_ctrl, unit_in0, unit_in1} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got req_ready=%b rsp_valid=%b unit_valid=%b unit_sel=%0d want all 0",
                     req_ready, rsp_valid, unit_valid, unit_sel);
        end
        rst = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_data, rsp_err, unit_valid, unit_sel} !== '0) begin
            failures++;
            $display("FAIL post_reset_idle: got req_ready=%b rsp_valid=%b unit_valid=%b want all 0",
                     req_ready, rsp_valid, unit_valid);
        end
    endtask

    task automatic test_single();
        do_reset();
        set_req(2, 3'd1, 32'd0, 32'd5, 32'd7);
        unit_ready = 1'b1;
        unit_done  = 1'b1;
        unit_out   = 32'd12;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin failures++; $display("FAIL single_grant: got %b want 0100", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        checks++;
        if ({unit_valid, unit_sel, unit_in0, unit_in1} !== {1'b1, 3'd1, 32'd5, 32'd7}) begin
            failures++;
            $display("FAIL single_issue: got valid=%b sel=%0d in0=%0d in1=%0d want 1/1/5/7", unit_valid, unit_sel, unit_in0, unit_in1);
        end
        @(negedge clk); #1;
        checks++;
        if ({rsp_valid, rsp_data, rsp_err} !== {4'b0100, 32'd12, 1'b0}) begin
            failures++;
            $display("FAIL single_rsp: got rsp_valid=%b data=%0d err=%b want 0100/12/0", rsp_valid, rsp_data, rsp_err);
        end
        @(negedge clk); #1;
        checks++;
        if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL single_rsp_pulse: got %b want 0000", rsp_valid); end
    endtask

    task automatic test_round_robin();
        int gseq[$];
        int rseq[$];
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int idx;
        do_reset();
        for (int t = 0; t < N; t++) set_req(t, S'(t + 1), W'(t), W'(100 * t), W'(t + 3));
        unit_ready = 1'b1;
        unit_done  = 1'b1;
        for (int cyc = 0; cyc < 15; cyc++) begin
            #1;
            unit_out = unit_fn(unit_sel, unit_ctrl, unit_in0, unit_in1);
            #1;
            if (req_ready != '0) begin
                checks++;
                if (!$onehot(req_ready)) begin failures++; $display("FAIL rr_onehot: got %b want one-hot", req_ready); end
                idx = 0;
                for (int i = 0; i < N; i++) if (req_ready[i]) idx = i;
                gseq.push_back(idx);
            end
            if (rsp_valid != '0) begin
                idx = 0;
                for (int i = 0; i < N; i++) if (rsp_valid[i]) idx = i;
                rseq.push_back(idx);
                checks++;
                if (rsp_data !== unit_fn(S'(idx + 1), W'(idx), W'(100 * idx), W'(idx + 3))) begin
                    failures++;
                    $display("FAIL rr_rsp_data: thread %0d got %h want %h", idx, rsp_data,
                             unit_fn(S'(idx + 1), W'(idx), W'(100 * idx), W'(idx + 3)));
                end
            end
            @(negedge clk);
        end
        checks++;
        if (gseq.size() != 5 || rseq.size() != 5) begin
            failures++;
            $display("FAIL rr_counts: got grants=%0d rsps=%0d want 5/5", gseq.size(), rseq.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (gseq[i] != exp_order[i] || rseq[i] != exp_order[i]) begin
                    failures++;
                    $display("FAIL rr_order[%0d]: got grant=%0d rsp=%0d want %0d", i, gseq[i], rseq[i], exp_order[i]);
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_sel_none();
        do_reset();
        unit_done = 1'b1;
        unit_out  = 32'hDEAD_BEEF;
        repeat (2) begin
            #1;
            checks++;
            if (rsp_valid !== '0) begin failures++; $display("FAIL spurious_done_idle: got %b want 0000", rsp_valid); end
            @(negedge clk);
        end
        unit_done  = 1'b0;
        unit_ready = 1'b1;
        set_req(1, 3'd0, $urandom, $urandom, $urandom);
        #1;
        checks++;
        if ({req_ready, unit_valid} !== {4'b0010, 1'b0}) begin
            failures++;
            $display("FAIL none_grant: got ready=%b unit_valid=%b want 0010/0", req_ready, unit_valid);
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        checks++;
        if ({rsp_valid, rsp_data, unit_valid} !== {4'b0010, 32'd0, 1'b0}) begin
            failures++;
            $display("FAIL none_rsp: got rsp_valid=%b data=%h unit_valid=%b want 0010/0/0", rsp_valid, rsp_data, unit_valid);
        end
        @(negedge clk); #1;
        checks++;
        if (rsp_valid !== '0) begin failures++; $display("FAIL none_rsp_pulse: got %b want 0000", rsp_valid); end
        idle_inputs();
    endtask

    task automatic test_stall();
        logic [W-1:0] c = $urandom, a = $urandom, b = $urandom, r = $urandom;
        do_reset();
        set_req(3, 3'd5, c, a, b);
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin failures++; $display("FAIL stall_grant: got %b want 1000", req_ready); end
        @(negedge clk);
        req_valid = '0;
        for (int i = 0; i < 4; i++) begin
            unit_ready = (i == 3);
            #1;
            checks++;
            if ({unit_valid, unit_sel, unit_ctrl, unit_in0, unit_in1} !== {1'b1, 3'd5, c, a, b}) begin
                failures++;
                $display("FAIL stall_hold[%0d]: got valid=%b sel=%0d ctrl=%h in0=%h in1=%h", i, unit_valid, unit_sel, unit_ctrl, unit_in0, unit_in1);
            end
            @(negedge clk);
        end
        unit_ready = 1'b0;
        #1;
        checks++;
        if ({unit_valid, unit_sel, unit_ctrl, unit_in0, unit_in1, rsp_valid} !== {1'b0, 3'd5, c, a, b, 4'b0000}) begin
            failures++;
            $display("FAIL stall_wait: got valid=%b sel=%0d rsp_valid=%b want 0/5/0000", unit_valid, unit_sel, rsp_valid);
        end
        @(negedge clk);
        unit_done = 1'b1;
        unit_out  = r;
        #1;
        checks++;
        if (rsp_valid !== '0) begin failures++; $display("FAIL stall_early_rsp: got %b want 0000", rsp_valid); end
        @(negedge clk);
        unit_done = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, rsp_data} !== {4'b1000, r}) begin
            failures++;
            $display("FAIL stall_rsp: got rsp_valid=%b data=%h want 1000/%h", rsp_valid, rsp_data, r);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_req(2, 3'd1, 32'd1, 32'd2, 32'd3);
        unit_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin failures++; $display("FAIL mid_grant: got %b want 0100", req_ready); end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        unit_ready = 1'b0;
        #1;
        checks++;
        if ({unit_valid, unit_sel} !== {1'b0, 3'd1}) begin
            failures++;
            $display("FAIL mid_in_wait: got valid=%b sel=%0d want 0/1", unit_valid, unit_sel);
        end
        rst = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_data, rsp_err, unit_valid, unit_sel, unit_ctrl, unit_in0, unit_in1} !== '0) begin
            failures++;
            $display("FAIL mid_reset_outputs: got rsp_valid=%b unit_valid=%b unit_sel=%0d want all 0", rsp_valid, unit_valid, unit_sel);
        end
        rst = 1'b0;
        unit_done = 1'b1;
        unit_out  = 32'h1234;
        repeat (3) begin
            #1;
            checks++;
            if (rsp_valid !== '0) begin failures++; $display("FAIL mid_no_rsp: got %b want 0000", rsp_valid); end
            @(negedge clk);
        end
        unit_done = 1'b0;
        for (int t = 0; t < N; t++) set_req(t, 3'd1, '0, '0, '0);
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin failures++; $display("FAIL mid_next_grant: got %b want 0001", req_ready); end
        do_reset();
    endtask

    task automatic test_timeout();
        int first_k = -1;
        int n_rsp = 0;
        logic [W-1:0] got_data = '0;
        logic got_err = 1'b0;
        do_reset();
        set_req(0, 3'd2, $urandom, $urandom, $urandom);
        unit_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin failures++; $display("FAIL to_grant: got %b want 0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        for (int k = 1; k <= 40; k++) begin
            #1;
            if (rsp_valid != '0) begin
                n_rsp++;
                if (first_k < 0) begin first_k = k; got_data = rsp_data; got_err = rsp_err; end
            end
            @(negedge clk);
        end
`ifdef UNIT_ARB_TIMEOUT_EN
        checks++;
        if (first_k != TO + 1 || n_rsp != 1 || got_err !== 1'b1 || got_data !== '0) begin
            failures++;
            $display("FAIL timeout_rsp: got at=%0d count=%0d err=%b data=%h want at=%0d count=1 err=1 data=0",
                     first_k, n_rsp, got_err, got_data, TO + 1);
        end
`else
        checks++;
        if (n_rsp != 0) begin failures++; $display("FAIL no_timeout: got %0d responses want 0", n_rsp); end
`endif
        do_reset();
    endtask

    task automatic test_random(input int ncyc);
        int rr = 0, owner = 0, gcyc = 0, dcyc = -1, u_cnt = 0, ws = 0, grants = 0, found;
        bit busy = 0, acc = 0, u_pend = 0, exp_uv, drain;
        logic [S-1:0] s_sel = '0;
        logic [W-1:0] s_ctrl = '0, s_in0 = '0, s_in1 = '0, exp_data = '0, u_res = '0;
        logic [N-1:0] exp_ready, exp_rsp;
        do_reset();
        for (int cyc = 0; cyc < ncyc + 60; cyc++) begin
            drain = (cyc >= ncyc);
            if (drain && !busy) break;
            exp_uv = busy && (s_sel != '0) && !acc && (cyc > gcyc);
            for (int t = 0; t < N; t++) begin
                req_valid[t]       = !drain && ($urandom_range(0, 2) == 0);
                req_sel[t*S +: S]  = S'($urandom_range(0, 7));
                req_ctrl[t*W +: W] = $urandom;
                req_in0[t*W +: W]  = $urandom;
                req_in1[t*W +: W]  = $urandom;
            end
            unit_ready = (ws >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
            ws         = (exp_uv && !unit_ready) ? ws + 1 : 0;
            unit_done  = 1'b0;
            unit_out   = $urandom;
            if (u_pend) begin
                u_cnt--;
                if (u_cnt == 0) begin unit_done = 1'b1; unit_out = u_res; u_pend = 0; end
            end else if (!busy) begin
                unit_done = 1'($urandom_range(0, 1));
            end
            #1;
            if (unit_valid && unit_ready) begin
                u_res = unit_fn(unit_sel, unit_ctrl, unit_in0, unit_in1);
                u_cnt = $urandom_range(0, 2);
                if (u_cnt == 0) begin unit_done = 1'b1; unit_out = u_res; end
                else u_pend = 1;
                #1;
            end
            exp_ready = '0;
            found = -1;
            if (!busy) begin
                for (int k = 0; k < N; k++)
                    if (found < 0 && req_valid[(rr + k) % N]) found = (rr + k) % N;
                if (found >= 0) exp_ready[found] = 1'b1;
            end
            checks++;
            if (req_ready !== exp_ready) begin failures++; $display("FAIL rand_grant@%0d: got %b want %b", cyc, req_ready, exp_ready); end
            if (found >= 0) begin
                busy = 1; owner = found; gcyc = cyc; acc = 0; grants++;
                s_sel  = req_sel[owner*S +: S];
                s_ctrl = req_ctrl[owner*W +: W];
                s_in0  = req_in0[owner*W +: W];
                s_in1  = req_in1[owner*W +: W];
                dcyc     = (s_sel == '0) ? cyc : -1;
                exp_data = '0;
            end
            checks++;
            if (unit_valid !== exp_uv) begin failures++; $display("FAIL rand_unit_valid@%0d: got %b want %b", cyc, unit_valid, exp_uv); end
            if (exp_uv) begin
                checks++;
                if ({unit_sel, unit_ctrl, unit_in0, unit_in1} !== {s_sel, s_ctrl, s_in0, s_in1}) begin
                    failures++;
                    $display("FAIL rand_unit_fields@%0d: got sel=%0d in0=%h want sel=%0d in0=%h", cyc, unit_sel, unit_in0, s_sel, s_in0);
                end
                if (unit_ready) acc = 1;
            end
            if (busy && acc && dcyc < 0 && unit_done) begin
                dcyc = cyc;
                exp_data = unit_fn(s_sel, s_ctrl, s_in0, s_in1);
            end
            exp_rsp = '0;
            if (busy && dcyc >= 0 && cyc == dcyc + 1) exp_rsp[owner] = 1'b1;
            checks++;
            if (rsp_valid !== exp_rsp) begin failures++; $display("FAIL rand_rsp_valid@%0d: got %b want %b", cyc, rsp_valid, exp_rsp); end
            if (exp_rsp != '0) begin
                checks++;
                if ({rsp_data, rsp_err} !== {exp_data, 1'b0}) begin
                    failures++;
                    $display("FAIL rand_rsp_data@%0d: got %h err=%b want %h err=0", cyc, rsp_data, rsp_err, exp_data);
                end
                busy = 0;
                rr   = (owner + 1) % N;
            end
            @(negedge clk);
        end
        checks++;
        if (busy || grants == 0) begin
            failures++;
            $display("FAIL rand_drain: got busy=%0d grants=%0d want idle with grants>0", busy, grants);
        end
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_sel_none();
        test_stall();
        test_reset_mid();
        test_timeout();
        test_random(800);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
